// File: rtl/huffman_xy_extend.sv
// huffman_xy_extend
//   Extends decoded big-values Huffman (x, y) magnitude pairs with their linbits
//   escape field and sign bits, read MSB-first from the serial bit stream in ISO
//   order (x linbits, x sign, y linbits, y sign). Emits signed spectral values
//   with a running frequency-line index for the requantizer buffer.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   gr_start            new-granule pulse: clears line index/done, aborts a pair
//   ht_valid            strobe: ht_x/ht_y/linbits hold a decoded pair
//   ht_x, ht_y          decoded magnitudes 0..15
//   linbits             linbits of the active table, 0..13
//   axiiv, axiid        serial bit valid/data
//   bits_req            waiting for extension or sign bits
//   axiov               strobe: x_out, y_out, idx valid
//   x_out, y_out        signed values; y_out is at line idx+1
//   idx                 frequency line of x_out
//   done                sticky: last pair of the granule emitted
//   err                 one-cycle pulse on a protocol violation (cycle after cause)
//   bits_used           (HUFF_BITCOUNT_EN only) saturating count of consumed bits
//
// Build option
//   HUFF_BITCOUNT_EN    adds the bits_used output and its counter.

module huffman_xy_extend #(
  parameter int unsigned LINES = 576,
  parameter int unsigned OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gr_start,
  input  logic             ht_valid,
  input  logic [3:0]       ht_x,
  input  logic [3:0]       ht_y,
  input  logic [3:0]       linbits,
  input  logic             axiiv,
  input  logic             axiid,
  output logic             bits_req,
  output logic             axiov,
  output logic [OUT_W-1:0] x_out,
  output logic [OUT_W-1:0] y_out,
  output logic [9:0]       idx,
  output logic             done,
`ifdef HUFF_BITCOUNT_EN
  output logic [15:0]      bits_used,
`endif
  output logic             err
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StXLin  = 3'd1,
    StXSign = 3'd2,
    StYLin  = 3'd3,
    StYSign = 3'd4,
    StEmit  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  x_raw_q, x_raw_d;
  logic [3:0]  y_raw_q, y_raw_d;
  logic [3:0]  lb_q, lb_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] acc_q, acc_d;
  logic [13:0] x_mag_q, x_mag_d;
  logic [13:0] y_mag_q, y_mag_d;
  logic        x_neg_q, x_neg_d;
  logic        y_neg_q, y_neg_d;
  logic [9:0]  line_q, line_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [12:0] acc_shift;
  logic        lin_last;
  logic [10:0] line_sum;
  logic        hv_bad;

  // First state at or after 'from' that actually needs bits; EMIT if none do.
  // States are ordered so that the later checks override the earlier ones.
  function automatic state_e first_active(input state_e     from,
                                          input logic [3:0] x,
                                          input logic [3:0] y,
                                          input logic [3:0] lb);
    state_e s;
    s = StEmit;
    if (from <= StYSign && y != 4'd0) s = StYSign;
    if (from <= StYLin && y == 4'd15 && lb != 4'd0) s = StYLin;
    if (from <= StXSign && x != 4'd0) s = StXSign;
    if (from <= StXLin && x == 4'd15 && lb != 4'd0) s = StXLin;
    return s;
  endfunction

  always_comb begin
    state_d   = state_q;
    x_raw_d   = x_raw_q;
    y_raw_d   = y_raw_q;
    lb_d      = lb_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    x_mag_d   = x_mag_q;
    y_mag_d   = y_mag_q;
    x_neg_d   = x_neg_q;
    y_neg_d   = y_neg_q;
    line_d    = line_q;
    done_d    = done_q;
    acc_shift = {acc_q, axiid};
    lin_last  = (cnt_q == lb_q - 4'd1);
    line_sum  = {1'b0, line_q} + 11'd2;
    hv_bad    = (state_q != StIdle) || done_q || (linbits > 4'd13);
    // gr_start alongside ht_valid drops the pair, so it counts as a violation.
    err_d     = ht_valid && (hv_bad || gr_start);

    unique case (state_q)
      StIdle: begin
        if (ht_valid && !hv_bad) begin
          x_raw_d = ht_x;
          y_raw_d = ht_y;
          lb_d    = linbits;
          x_mag_d = {10'd0, ht_x};
          y_mag_d = {10'd0, ht_y};
          x_neg_d = 1'b0;
          y_neg_d = 1'b0;
          cnt_d   = 4'd0;
          acc_d   = 12'd0;
          state_d = first_active(StXLin, ht_x, ht_y, linbits);
        end
      end
      StXLin: begin
        if (axiiv) begin
          if (lin_last) begin
            x_mag_d = 14'd15 + {1'b0, acc_shift};
            acc_d   = 12'd0;
            cnt_d   = 4'd0;
            state_d = first_active(StXSign, x_raw_q, y_raw_q, lb_q);
          end else begin
            acc_d = acc_shift[11:0];
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StXSign: begin
        if (axiiv) begin
          x_neg_d = axiid;
          state_d = first_active(StYLin, x_raw_q, y_raw_q, lb_q);
        end
      end
      StYLin: begin
        if (axiiv) begin
          if (lin_last) begin
            y_mag_d = 14'd15 + {1'b0, acc_shift};
            acc_d   = 12'd0;
            cnt_d   = 4'd0;
            state_d = first_active(StYSign, x_raw_q, y_raw_q, lb_q);
          end else begin
            acc_d = acc_shift[11:0];
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StYSign: begin
        if (axiiv) begin
          y_neg_d = axiid;
          state_d = StEmit;
        end
      end
      StEmit: begin
        line_d  = line_sum[9:0];
        if (line_sum == 11'(LINES)) done_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (gr_start) begin
      state_d = StIdle;
      line_d  = 10'd0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      x_raw_q <= 4'd0;
      y_raw_q <= 4'd0;
      lb_q    <= 4'd0;
      cnt_q   <= 4'd0;
      acc_q   <= 12'd0;
      x_mag_q <= 14'd0;
      y_mag_q <= 14'd0;
      x_neg_q <= 1'b0;
      y_neg_q <= 1'b0;
      line_q  <= 10'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_raw_q <= x_raw_d;
      y_raw_q <= y_raw_d;
      lb_q    <= lb_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_mag_q <= x_mag_d;
      y_mag_q <= y_mag_d;
      x_neg_q <= x_neg_d;
      y_neg_q <= y_neg_d;
      line_q  <= line_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  logic [OUT_W-1:0] x_ext, y_ext;

  always_comb begin
    x_ext    = {{(OUT_W-14){1'b0}}, x_mag_q};
    y_ext    = {{(OUT_W-14){1'b0}}, y_mag_q};
    x_out    = x_neg_q ? ('0 - x_ext) : x_ext;
    y_out    = y_neg_q ? ('0 - y_ext) : y_ext;
    bits_req = (state_q == StXLin) || (state_q == StXSign) ||
               (state_q == StYLin) || (state_q == StYSign);
    axiov    = (state_q == StEmit);
    idx      = line_q;
    done     = done_q;
    err      = err_q;
  end

`ifdef HUFF_BITCOUNT_EN
  logic [15:0] bitcnt_q, bitcnt_d;

  always_comb begin
    bitcnt_d = bitcnt_q;
    if (bits_req && axiiv && bitcnt_q != 16'hFFFF) bitcnt_d = bitcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst || gr_start) begin
      bitcnt_q <= 16'd0;
    end else begin
      bitcnt_q <= bitcnt_d;
    end
  end

  assign bits_used = bitcnt_q;
`endif

endmodule

// File: doc/huffman_xy_extend.md
Name: huffman_xy_extend

Overview:
- Sits directly downstream of the big-values Huffman pair decoder in the MP3 parser.
- Takes each decoded (x, y) magnitude pair, then consumes the bits that follow the codeword on the same serial stream: linbits escape extension and a sign bit for each value, in ISO order.
- Emits signed spectral values with a running frequency-line index (0..575) for the requantizer buffer.

Parameters:
- LINES, 576, frequency lines per granule; index range 0..LINES-1.
- OUT_W, 16, width of the signed x/y outputs.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- gr_start  input  1  one-cycle pulse; clears the line index and done for a new granule
- ht_valid  input  1  one-cycle strobe; ht_x/ht_y hold a decoded pair
- ht_x  input  4  decoded x magnitude, 0..15
- ht_y  input  4  decoded y magnitude, 0..15
- linbits  input  4  linbits of the active table, 0..13; sampled at ht_valid
- axiiv  input  1  serial bit valid
- axiid  input  1  serial bit data
- bits_req  output  1  high while the block is waiting for extension or sign bits
- axiov  output  1  one-cycle strobe; x_out, y_out and idx are valid
- x_out  output  OUT_W  signed x value
- y_out  output  OUT_W  signed y value
- idx  output  10  frequency line of x_out; y_out is at idx+1
- done  output  1  sticky; set after the pair at lines LINES-2/LINES-1 is emitted
- err  output  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset values: state IDLE; axiov, bits_req, err, done = 0; x_out, y_out = 0; idx = 0; internal line counter = 0.
- rst has priority over every other input. Reset mid-operation aborts the pair and returns to IDLE; no axiov is produced for the aborted pair.
- States and transitions:
  - IDLE: on ht_valid with done=0, capture ht_x, ht_y and linbits, then go to XLIN.
  - XLIN: active only if x==15 and linbits>0; otherwise pass through in zero cycles. Shift in linbits bits MSB-first, one per axiiv cycle. x := 15 + value.
  - XSIGN: active only if x!=0. One bit; 1 means negative.
  - YLIN and YSIGN: same rules applied to y.
  - EMIT: go to EMIT once all required bits are consumed.
- The next-state decision skips inactive states combinationally, so a pair needing no bits reaches EMIT the cycle after ht_valid.
- EMIT lasts one cycle:
  - axiov=1; x_out/y_out carry the two's-complement signed values; idx = current line counter.
  - Line counter += 2.
  - If the counter reaches LINES, set done.
  - Return to IDLE.
- Latency: axiov is asserted exactly 1 cycle after the last required bit, or 1 cycle after ht_valid if no bits are required.
- bits_req=1 in XLIN, XSIGN, YLIN and YSIGN; 0 otherwise.
- Bits with axiiv=1 while bits_req=0 are ignored, with no error.
- A cycle with axiiv=0 in a bit-consuming state stalls the state.
- Arithmetic:
  - Magnitude is at most 15 + 8191 = 8206, so it fits in 14 bits.
  - Sign applied as 0 - magnitude, sign-extended to OUT_W.
  - Negative zero is never produced, because a zero value reads no sign bit.
- Errors (err pulses for one cycle; the input is otherwise ignored):
  - ht_valid while not in IDLE.
  - ht_valid while done=1.
  - ht_valid with linbits > 13.
- gr_start: clears the line counter and done the next cycle. If received while busy, it also aborts the pair to IDLE without axiov. gr_start together with ht_valid means gr_start wins; the pair is dropped and err pulses.
- idx wraps only through gr_start or rst, never by overflow.

Optional Feature:
- Macro HUFF_BITCOUNT_EN.
- When defined, adds output port bits_used (16 bits):
  - Counts every bit accepted in XLIN, XSIGN, YLIN and YSIGN.
  - Cleared by rst and gr_start.
  - Saturates at 16'hFFFF.
  - Used by the parser to check against part2_3_length.
- When not defined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- rst, gr_start, then ht_valid with x=0, y=0, linbits=0 → axiov 1 cycle later; x_out=0, y_out=0, idx=0; bits_req stays 0.
- ht_valid with x=15, y=3, linbits=4; serial bits 1,0,1,0 (x linbits = 10), 1 (x sign), 0 (y sign) → x_out=-25, y_out=+3, idx=2; axiov 1 cycle after the 6th bit.
- Same pair as the previous scenario, with axiiv gaps of 3 idle cycles between bits → identical outputs; bits_req held high throughout the gaps.
- 288 pairs with x=1, y=0; sign bits alternating 0/1 → the last pair has idx=574; done=1 afterwards; a 289th ht_valid gives an err pulse and no axiov.
- Second ht_valid during XLIN → err pulse; the first pair completes correctly. rst asserted during YSIGN → no axiov; all outputs at reset values the next cycle.
- With HUFF_BITCOUNT_EN defined, run the x=15/y=3 scenario → bits_used=6; gr_start → bits_used=0.
